day015_sync_fifo_ctrl: RTL and testbench

//  Synchronous FIFO controller built around a day014_dual_port_ram instance:
//   - RAM port A is write-only; RAM port B is read-only.

---
 rtl/day015_fifo_pkg.sv | 26 ++
 rtl/day014_dual_port_ram.sv | 25 ++
 rtl/day015_fifo_ptr.sv | 25 ++
 rtl/day015_sync_fifo_ctrl.sv | 105 ++++++++++
 tb/tb_day015_sync_fifo_ctrl.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/day015_fifo_pkg.sv
// Shared helpers and defaults for the day015 synchronous FIFO slice.
package day015_fifo_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_DEPTH      = 8;

  // Number of bits needed to represent v (minimum 1).
  function automatic int unsigned clogb2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = v;
    for (int unsigned i = 0; i < 32; i++) begin
      if (x != 0) begin
        r = r + 1;
        x = x >> 1;
      end
    end
    return (r == 0) ? 1 : r;
  endfunction

  localparam int unsigned DEF_ADDR_WIDTH = clogb2(DEF_DEPTH - 1);

  typedef logic [DEF_ADDR_WIDTH:0] ptr_t;

endpackage

// File: rtl/day014_dual_port_ram.sv
// Dual-port RAM, one clock, registered read on port B; contents have no reset.
module day014_dual_port_ram #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                  clk_i,
  input  logic                  we_a_i,
  input  logic [ADDR_WIDTH-1:0] addr_a_i,
  input  logic [DATA_WIDTH-1:0] data_in_a_i,
  input  logic                  we_b_i,
  input  logic [ADDR_WIDTH-1:0] addr_b_i,
  input  logic [DATA_WIDTH-1:0] data_in_b_i,
  output logic [DATA_WIDTH-1:0] data_out_b_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_a_i) mem_q[addr_a_i] <= data_in_a_i;
    if (we_b_i) mem_q[addr_b_i] <= data_in_b_i;
    data_out_b_o <= mem_q[addr_b_i];
  end

endmodule

// File: rtl/day015_fifo_ptr.sv
// FIFO pointer: low bits address the RAM, MSB is the wrap bit.
module day015_fifo_ptr #(
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              inc_i,
  output logic [ADDR_WIDTH:0] ptr_o
);

  logic [ADDR_WIDTH:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (inc_i) ptr_d = ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/day015_sync_fifo_ctrl.sv
// Synchronous FIFO controller: turns a dual-port RAM (A write, B read) into an
// ordered FIFO with registered status, a read-valid strobe and sticky error flags.
module day015_sync_fifo_ctrl
  import day015_fifo_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int unsigned DEPTH      = DEF_DEPTH,
  localparam int unsigned ADDR_WIDTH = clogb2(DEPTH - 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  typedef logic [ADDR_WIDTH:0] fifo_ptr_t;

  fifo_ptr_t wr_ptr, rd_ptr, wr_ptr_nx, rd_ptr_nx;
  fifo_ptr_t count_q, count_d;
  logic full_q, full_d, empty_q, empty_d;
  logic ovf_q, ovf_d, unf_q, unf_d;
  logic rd_valid_q;
  logic wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] ram_rdata, rd_hold_q;

  always_comb begin
    wr_acc    = wr_en_i && !full_q;
    rd_acc    = rd_en_i && !empty_q;
    wr_ptr_nx = wr_ptr + fifo_ptr_t'(wr_acc);
    rd_ptr_nx = rd_ptr + fifo_ptr_t'(rd_acc);
    full_d    = (wr_ptr_nx[ADDR_WIDTH-1:0] == rd_ptr_nx[ADDR_WIDTH-1:0]) &&
                (wr_ptr_nx[ADDR_WIDTH] != rd_ptr_nx[ADDR_WIDTH]);
    empty_d   = (wr_ptr_nx == rd_ptr_nx);
    count_d   = count_q + fifo_ptr_t'(wr_acc) - fifo_ptr_t'(rd_acc);
    ovf_d     = ovf_q | (wr_en_i & full_q);
    unf_d     = unf_q | (rd_en_i & empty_q);
  end

  day015_fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_ptr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (wr_acc),
    .ptr_o (wr_ptr)
  );

  day015_fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_ptr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (rd_acc),
    .ptr_o (rd_ptr)
  );

  day014_dual_port_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk_i        (clk_i),
    .we_a_i       (wr_acc),
    .addr_a_i     (wr_ptr[ADDR_WIDTH-1:0]),
    .data_in_a_i  (wr_data_i),
    .we_b_i       (1'b0),
    .addr_b_i     (rd_ptr[ADDR_WIDTH-1:0]),
    .data_in_b_i  ('0),
    .data_out_b_o (ram_rdata)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_hold_q  <= '0;
    end else begin
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      rd_valid_q <= rd_acc;
      if (rd_valid_q) rd_hold_q <= ram_rdata;
    end
  end

  // RAM output is unreset and free-running; the hold register gives reset-zero and hold semantics.
  assign rd_data_o   = rd_valid_q ? ram_rdata : rd_hold_q;
  assign rd_valid_o  = rd_valid_q;
  assign full_o      = full_q;
  assign empty_o     = empty_q;
  assign count_o     = count_q;
  assign overflow_o  = ovf_q;
  assign underflow_o = unf_q;

endmodule

// File: tb/tb_day015_sync_fifo_ctrl.sv
// Directed self-checking bench for day015_sync_fifo_ctrl (DATA_WIDTH=8, DEPTH=8).
module tb_day015_sync_fifo_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       wr_en_i;
  logic [7:0] wr_data_i;
  logic       rd_en_i;
  logic [7:0] rd_data_o;
  logic       rd_valid_o;
  logic       full_o;
  logic       empty_o;
  logic [3:0] count_o;
  logic       overflow_o;
  logic       underflow_o;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  day015_sync_fifo_ctrl #(.DATA_WIDTH(8), .DEPTH(8)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .wr_en_i     (wr_en_i),
    .wr_data_i   (wr_data_i),
    .rd_en_i     (rd_en_i),
    .rd_data_o   (rd_data_o),
    .rd_valid_o  (rd_valid_o),
    .full_o      (full_o),
    .empty_o     (empty_o),
    .count_o     (count_o),
    .overflow_o  (overflow_o),
    .underflow_o (underflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  logic [7:0] exp_seq [10];

  initial begin
    rst_i = 1'b1; wr_en_i = 1'b0; rd_en_i = 1'b0; wr_data_i = '0;
    #12;
    check("rst_count", count_o, 0);
    check("rst_empty", empty_o, 1);
    check("rst_full", full_o, 0);
    check("rst_valid", rd_valid_o, 0);
    check("rst_data", rd_data_o, 0);
    check("rst_ovf", overflow_o, 0);
    check("rst_unf", underflow_o, 0);
    rst_i = 1'b0;
    #2;

    // 1) fill with 1..8
    for (int i = 1; i <= 8; i++) begin
      wr_en_i = 1'b1; wr_data_i = 8'(i);
      tick();
      check("t1_count", count_o, i);
    end
    wr_en_i = 1'b0;
    check("t1_full", full_o, 1);
    check("t1_empty", empty_o, 0);

    // 2) drain, data one cycle after each accepted read
    for (int i = 1; i <= 8; i++) begin
      rd_en_i = 1'b1;
      tick();
      check("t2_valid", rd_valid_o, 1);
      check("t2_data", rd_data_o, i);
    end
    rd_en_i = 1'b0;
    tick();
    check("t2_empty", empty_o, 1);
    check("t2_valid_low", rd_valid_o, 0);
    check("t2_hold", rd_data_o, 8);
    check("t2_unf_clear", underflow_o, 0);

    // 3) overflow then underflow
    for (int i = 0; i < 8; i++) begin
      wr_en_i = 1'b1; wr_data_i = 8'(21 + i);
      tick();
    end
    check("t3_full", full_o, 1);
    check("t3_ovf_pre", overflow_o, 0);
    wr_data_i = 8'd99;
    tick();
    wr_en_i = 1'b0;
    check("t3_ovf", overflow_o, 1);
    check("t3_count", count_o, 8);
    for (int i = 0; i < 8; i++) begin
      rd_en_i = 1'b1;
      tick();
      check("t3_data", rd_data_o, 21 + i);
    end
    tick();
    check("t3_empty", empty_o, 1);
    check("t3_valid_low", rd_valid_o, 0);
    check("t3_unf", underflow_o, 1);
    rd_en_i = 1'b0;
    tick();

    // 4) 4 entries, then simultaneous read+write across the wrap
    exp_seq = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15};
    for (int i = 1; i <= 4; i++) begin
      wr_en_i = 1'b1; wr_data_i = 8'(i);
      tick();
    end
    for (int i = 0; i < 6; i++) begin
      wr_en_i = 1'b1; rd_en_i = 1'b1; wr_data_i = 8'(10 + i);
      tick();
      check("t4_count", count_o, 4);
      check("t4_valid", rd_valid_o, 1);
      check("t4_data", rd_data_o, exp_seq[i]);
    end
    wr_en_i = 1'b0;
    for (int i = 6; i < 10; i++) begin
      rd_en_i = 1'b1;
      tick();
      check("t4_data", rd_data_o, exp_seq[i]);
    end
    rd_en_i = 1'b0;
    tick();
    check("t4_empty", empty_o, 1);

    // 5) full with both enables: read only, write dropped
    rst_i = 1'b1; #2; rst_i = 1'b0;
    check("t5_ovf_cleared", overflow_o, 0);
    check("t5_unf_cleared", underflow_o, 0);
    for (int i = 0; i < 8; i++) begin
      wr_en_i = 1'b1; wr_data_i = 8'(30 + i);
      tick();
    end
    wr_en_i = 1'b1; rd_en_i = 1'b1; wr_data_i = 8'd77;
    tick();
    wr_en_i = 1'b0; rd_en_i = 1'b0;
    check("t5_count", count_o, 7);
    check("t5_ovf", overflow_o, 1);
    check("t5_full", full_o, 0);
    check("t5_data", rd_data_o, 30);
    for (int i = 1; i < 8; i++) begin
      rd_en_i = 1'b1;
      tick();
      check("t5_drain", rd_data_o, 30 + i);
    end
    rd_en_i = 1'b0;
    tick();
    check("t5_empty", empty_o, 1);

    // 6) asynchronous reset mid-burst
    for (int i = 0; i < 3; i++) begin
      wr_en_i = 1'b1; wr_data_i = 8'(8'h50 + i);
      tick();
    end
    wr_en_i = 1'b0; rd_en_i = 1'b1;
    tick();
    check("t6_pre_valid", rd_valid_o, 1);
    check("t6_pre_data", rd_data_o, 8'h50);
    #2 rst_i = 1'b1;
    #1;
    check("t6_count", count_o, 0);
    check("t6_empty", empty_o, 1);
    check("t6_full", full_o, 0);
    check("t6_valid", rd_valid_o, 0);
    check("t6_data", rd_data_o, 0);
    rd_en_i = 1'b0;
    #1 rst_i = 1'b0;
    wr_en_i = 1'b1; wr_data_i = 8'hA5;
    tick();
    wr_en_i = 1'b0; rd_en_i = 1'b1;
    tick();
    rd_en_i = 1'b0;
    check("t6_a5_valid", rd_valid_o, 1);
    check("t6_a5_data", rd_data_o, 8'hA5);
    check("t6_a5_count", count_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
